oven_cycle_ctrl: RTL and testbench
==================================

Name: oven_cycle_ctrl

Overview:
- Sequences one bake cycle for the oven heater: preheat to a setpoint, hold for a timed duration, cool down, then report done.
- Schedules temperature samples from the 12-bit ADC over a req/valid handshake.
- Drives the heater output with hysteresis.
- Sits between the front-panel inputs (start, stop, set_temp, set_timer) and the heater/display logic; exports state and remaining time for the display mux.

Parameters:
- TICK_DIV, 50000000: clk cycles per 1 s tick (50 MHz clock).
- SAMPLE_DIV, 500000: clk cycles between ADC requests.
- HYST, 2: hold-band hysteresis in °C.
- PREHEAT_MAX_S, 900: preheat timeout in seconds.
- COOL_TEMP, 50: °C below which cooldown completes.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  debounced start button, level; rising edge acts.
- stop  in  1  debounced stop button, level; rising edge acts.
- set_temp  in  8  target temperature in °C.
- set_timer  in  4  hold time in minutes, 1..15.
- adc_data  in  12  ADC conversion result.
- adc_valid  in  1  adc_data valid, single-cycle pulse.
- adc_req  out  1  conversion request, held until valid.
- heater  out  1  heater enable.
- state  out  3  IDLE=0, PREHEAT=1, HOLD=2, COOL=3, DONE=4, FAULT=5.
- cur_temp  out  8  last sampled temperature in °C.
- remaining_s  out  10  hold seconds remaining.
- done  out  1  cycle completed normally.
- fault  out  1  timeout or sensor fault.

Behaviour:
- Reset, asynchronous: state IDLE; heater, adc_req, done, fault = 0; cur_temp, remaining_s = 0; prescalers and edge-detect registers = 0. All outputs are registered.
- Edge detect: one register stage each on start and stop; an action fires the cycle after the rising edge is seen.
- Simultaneous start and stop edges: stop wins.
- ADC scheduler:
  - The sample counter runs in every state and pauses while a request is outstanding.
  - At SAMPLE_DIV-1 it asserts adc_req and holds it.
  - On adc_valid with adc_req high: cur_temp <= adc_data[11:4]; adc_req drops the next cycle; the counter restarts from 0.
  - adc_valid while adc_req is low is ignored.
- Sensor check: a captured value of 8'hFF in PREHEAT or HOLD is treated as an open sensor and goes to FAULT.
- IDLE:
  - heater = 0.
  - start edge with set_temp != 0 and set_timer != 0: latch target and minutes, remaining_s <= set_timer*60 (max 900), clear done, go to PREHEAT.
  - Any other start edge is ignored.
- PREHEAT:
  - heater = 1; a 1 s prescaler counts elapsed seconds.
  - Capture with cur_temp >= target goes to HOLD.
  - Elapsed seconds reaching PREHEAT_MAX_S goes to FAULT.
- HOLD:
  - The tick prescaler restarts on entry, so the first decrement occurs exactly TICK_DIV cycles after entry; each tick does remaining_s -= 1.
  - remaining_s reaching 0 goes to COOL.
  - Hysteresis, evaluated per capture: heater <= 0 if cur_temp >= target; heater <= 1 if cur_temp < target-HYST (subtraction saturates at 0); otherwise heater holds.
- COOL:
  - heater = 0.
  - Capture with cur_temp < COOL_TEMP: go to DONE with done = 1, or to IDLE if the cycle was aborted.
- DONE:
  - done stays high.
  - start edge begins a new cycle, same checks as IDLE.
  - stop edge goes to IDLE and clears done.
- FAULT:
  - heater = 0, fault = 1.
  - Start is ignored; only a stop edge clears it (IDLE, fault = 0).
- Stop in PREHEAT or HOLD: set the abort flag, go to COOL; heater goes low on the next edge. Stop in COOL is ignored.
- set_temp and set_timer changes after the start edge have no effect until the next cycle.
- Heater is forced to 0 in every state except PREHEAT and HOLD.

Test Plan:
All scenarios use TICK_DIV=10, SAMPLE_DIV=4, PREHEAT_MAX_S=5 and an ADC model that answers a request with adc_valid 2 cycles later.
1. Normal cycle:
   - Stimulus: set_temp=150, set_timer=1, start edge; ADC returns 2025 then 2416.
   - Required: state 1 with heater=1 and cur_temp=126; then cur_temp=151 and state 2; remaining_s counts 60 down to 0, one step per 10 cycles; state 3 with heater=0.
   - Then ADC 700: cur_temp=43, state 4, done=1.
2. Hysteresis in HOLD, target 150:
   - 151 gives heater=0; 149 keeps heater=0.
   - 147 gives heater=1; 149 keeps heater=1.
3. Preheat timeout:
   - ADC stuck at 1600 (100 °C).
   - After 5 ticks: state 5, fault=1, heater=0.
   - A start edge is ignored; a stop edge gives state 0 and fault=0.
4. Abort:
   - start and stop edges arrive in the same cycle while in HOLD: state 3 and heater=0 on the next edge.
   - ADC 700: state 0 with done=0.
5. Reset mid-PREHEAT:
   - rst_n low asynchronously between clock edges while heater=1.
   - Required: heater, adc_req, state and all other outputs go to 0 immediately, before the next clk edge.
6. Boundary:
   - set_timer=0 with a start edge: remains IDLE.
   - adc_valid with no request: cur_temp unchanged.
   - adc_data=4095 during PREHEAT: FAULT.

Source files
------------

// File: rtl/oven_cycle_ctrl.sv
// oven_cycle_ctrl -- bake-cycle sequencer for the oven heater.
//
// Runs one cycle as preheat -> hold (timed) -> cool -> done. It schedules ADC
// temperature samples over a req/valid handshake and drives the heater with
// hysteresis while holding. All outputs are registered.
//
// Ports:
//   clk          system clock (50 MHz nominal)
//   rst_n        asynchronous active-low reset
//   start, stop  debounced front-panel buttons (level, rising edge acts)
//   set_temp     target temperature in degC
//   set_timer    hold time in minutes, 1..15
//   adc_data     12-bit ADC result (top 8 bits are degC)
//   adc_valid    single-cycle result strobe
//   adc_req      conversion request, held until adc_valid
//   heater       heater enable
//   state        IDLE=0 PREHEAT=1 HOLD=2 COOL=3 DONE=4 FAULT=5
//   cur_temp     last sampled temperature in degC
//   remaining_s  hold seconds remaining
//   done         cycle completed normally
//   fault        preheat timeout or open sensor
module oven_cycle_ctrl #(
  parameter int TICK_DIV      = 50000000,
  parameter int SAMPLE_DIV    = 500000,
  parameter int HYST          = 2,
  parameter int PREHEAT_MAX_S = 900,
  parameter int COOL_TEMP     = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  set_temp,
  input  logic [3:0]  set_timer,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  output logic        adc_req,
  output logic        heater,
  output logic [2:0]  state,
  output logic [7:0]  cur_temp,
  output logic [9:0]  remaining_s,
  output logic        done,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREHEAT = 3'd1,
    S_HOLD    = 3'd2,
    S_COOL    = 3'd3,
    S_DONE    = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SAMPLE_DIV + 1);
  localparam int EW = $clog2(PREHEAT_MAX_S + 1);

  // Lower hysteresis threshold must not wrap for small targets.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  state_t          state_q, state_nxt;
  logic            heater_nxt, done_nxt, fault_nxt;
  logic            abort_q, abort_nxt;
  logic [7:0]      target_q, target_nxt;
  logic [9:0]      remaining_nxt;
  logic [EW-1:0]   elapsed_q, elapsed_nxt;
  logic [TW-1:0]   tick_cnt;
  logic [SW-1:0]   samp_cnt;
  logic            start_q, stop_q;
  logic            start_edge, stop_edge, start_ok;
  logic            cap, sensor_open, in_timed, tick;
  logic [7:0]      cap_temp;
  logic            adc_lsb_unused;

  assign adc_lsb_unused = ^adc_data[3:0];

  assign start_edge  = start & ~start_q;
  assign stop_edge   = stop & ~stop_q;
  assign start_ok    = start_edge && (set_temp != 8'd0) && (set_timer != 4'd0);
  assign cap         = adc_valid & adc_req;
  assign cap_temp    = adc_data[11:4];
  assign sensor_open = cap && (cap_temp == 8'hFF);
  assign in_timed    = (state_q == S_PREHEAT) || (state_q == S_HOLD);
  assign tick        = in_timed && (tick_cnt == TW'(TICK_DIV - 1));
  assign state       = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
    end
  end

  // Sample scheduler: the counter freezes while a request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt <= '0;
      adc_req  <= 1'b0;
      cur_temp <= 8'd0;
    end else if (adc_req) begin
      if (adc_valid) begin
        cur_temp <= cap_temp;
        adc_req  <= 1'b0;
        samp_cnt <= '0;
      end
    end else if (samp_cnt == SW'(SAMPLE_DIV - 1)) begin
      adc_req <= 1'b1;
    end else begin
      samp_cnt <= samp_cnt + SW'(1);
    end
  end

  // 1 s prescaler restarts on every state change so HOLD's first tick lands
  // exactly TICK_DIV cycles after entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if ((state_nxt != state_q) || !in_timed || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      heater      <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      abort_q     <= 1'b0;
      target_q    <= 8'd0;
      remaining_s <= 10'd0;
      elapsed_q   <= '0;
    end else begin
      state_q     <= state_nxt;
      heater      <= heater_nxt;
      done        <= done_nxt;
      fault       <= fault_nxt;
      abort_q     <= abort_nxt;
      target_q    <= target_nxt;
      remaining_s <= remaining_nxt;
      elapsed_q   <= elapsed_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    heater_nxt    = heater;
    done_nxt      = done;
    fault_nxt     = fault;
    abort_nxt     = abort_q;
    target_nxt    = target_q;
    remaining_nxt = remaining_s;
    elapsed_nxt   = elapsed_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        heater_nxt = 1'b0;
        // Stop beats a simultaneous start; IDLE has nothing to stop.
        if ((state_q == S_DONE) && stop_edge) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b0;
        end else if (start_ok) begin
          state_nxt     = S_PREHEAT;
          target_nxt    = set_temp;
          remaining_nxt = 10'(set_timer) * 10'd60;
          elapsed_nxt   = '0;
          done_nxt      = 1'b0;
          abort_nxt     = 1'b0;
          heater_nxt    = 1'b1;
        end
      end
      S_PREHEAT: begin
        heater_nxt = 1'b1;
        if (stop_edge) begin
          state_nxt  = S_COOL;
          abort_nxt  = 1'b1;
          heater_nxt = 1'b0;
        end else if (sensor_open) begin
          state_nxt  = S_FAULT;
          fault_nxt  = 1'b1;
          heater_nxt = 1'b0;
        end else if (cap && (cap_temp >= target_q)) begin
          // At or above target on entry, so hysteresis starts with heater off.
          state_nxt  = S_HOLD;
          heater_nxt = 1'b0;
        end else if (tick) begin
          if (elapsed_q == EW'(PREHEAT_MAX_S - 1)) begin
            state_nxt  = S_FAULT;
            fault_nxt  = 1'b1;
            heater_nxt = 1'b0;
          end else begin
            elapsed_nxt = elapsed_q + EW'(1);
          end
        end
      end
      S_HOLD: begin
        if (stop_edge) begin
          state_nxt  = S_COOL;
          abort_nxt  = 1'b1;
          heater_nxt = 1'b0;
        end else if (sensor_open) begin
          state_nxt  = S_FAULT;
          fault_nxt  = 1'b1;
          heater_nxt = 1'b0;
        end else begin
          if (cap) begin
            if (cap_temp >= target_q) begin
              heater_nxt = 1'b0;
            end else if (cap_temp < sat_sub(target_q, 8'(HYST))) begin
              heater_nxt = 1'b1;
            end
          end
          if (tick) begin
            if (remaining_s <= 10'd1) begin
              remaining_nxt = 10'd0;
              state_nxt     = S_COOL;
              heater_nxt    = 1'b0;
            end else begin
              remaining_nxt = remaining_s - 10'd1;
            end
          end
        end
      end
      S_COOL: begin
        heater_nxt = 1'b0;
        if (cap && (cap_temp < 8'(COOL_TEMP))) begin
          if (abort_q) begin
            state_nxt = S_IDLE;
            abort_nxt = 1'b0;
          end else begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      S_FAULT: begin
        heater_nxt = 1'b0;
        if (stop_edge) begin
          state_nxt = S_IDLE;
          fault_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        heater_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oven_cycle_ctrl.sv
// Directed testbench for oven_cycle_ctrl with scaled-down timing
// (TICK_DIV=10, SAMPLE_DIV=4, PREHEAT_MAX_S=5). The ADC model answers a
// request with adc_valid two cycles after adc_req rises.
module tb_oven_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, stop;
  logic [7:0]  set_temp;
  logic [3:0]  set_timer;
  logic [11:0] adc_data;
  logic        adc_valid, adc_req, heater, done, fault;
  logic [2:0]  state;
  logic [7:0]  cur_temp;
  logic [9:0]  remaining_s;

  logic        auto_valid, man_valid, adc_auto;
  int          tests_run = 0;
  int          tests_failed = 0;

  assign adc_valid = auto_valid | man_valid;

  always #5 clk = ~clk;

  oven_cycle_ctrl #(
    .TICK_DIV(10), .SAMPLE_DIV(4), .HYST(2), .PREHEAT_MAX_S(5), .COOL_TEMP(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .set_temp(set_temp), .set_timer(set_timer),
    .adc_data(adc_data), .adc_valid(adc_valid), .adc_req(adc_req),
    .heater(heater), .state(state), .cur_temp(cur_temp),
    .remaining_s(remaining_s), .done(done), .fault(fault)
  );

  // ADC model: request seen at negedge, valid driven one cycle later.
  initial begin
    auto_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (adc_auto && adc_req) begin
        @(negedge clk);
        auto_valid = 1'b1;
        @(negedge clk);
        auto_valid = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int maxc);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((state !== s) && (n < maxc));
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    set_temp = 8'd0; set_timer = 4'd0; adc_data = 12'd0;
    man_valid = 1'b0; adc_auto = 1'b0;

    // Reset state
    cycles(2);
    check("rst_state", 32'(state), 0);
    check("rst_heater", 32'(heater), 0);
    check("rst_adc_req", 32'(adc_req), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_cur_temp", 32'(cur_temp), 0);
    check("rst_remaining", 32'(remaining_s), 0);
    @(negedge clk) rst_n = 1'b1;

    // 1. Normal cycle, 150 degC for 1 minute
    set_temp = 8'd150; set_timer = 4'd1; adc_data = 12'd2025; adc_auto = 1'b1;
    @(negedge clk) start = 1'b1;
    cycles(1);
    check("t1_preheat", 32'(state), 1);
    check("t1_heater_on", 32'(heater), 1);
    check("t1_remaining_init", 32'(remaining_s), 60);
    @(negedge clk) start = 1'b0;
    cycles(8);
    check("t1_temp126", 32'(cur_temp), 126);
    check("t1_still_preheat", 32'(state), 1);
    check("t1_heater_still_on", 32'(heater), 1);
    adc_data = 12'd2416;
    wait_state("t1_hold", 3'd2, 20);
    check("t1_temp151", 32'(cur_temp), 151);
    check("t1_hold_remaining", 32'(remaining_s), 60);
    for (int k = 1; k <= 60; k++) begin
      cycles(10);
      check("t1_countdown", 32'(remaining_s), 32'(60 - k));
    end
    check("t1_cool", 32'(state), 3);
    check("t1_cool_heater", 32'(heater), 0);
    adc_data = 12'd700;
    wait_state("t1_done_state", 3'd4, 20);
    check("t1_done", 32'(done), 1);
    check("t1_temp43", 32'(cur_temp), 43);
    check("t1_done_heater", 32'(heater), 0);

    // 2. Hysteresis in HOLD (new cycle started from DONE)
    adc_data = 12'd2416;
    @(negedge clk) start = 1'b1;
    cycles(1);
    check("t2_restart", 32'(state), 1);
    check("t2_done_clr", 32'(done), 0);
    @(negedge clk) start = 1'b0;
    wait_state("t2_hold", 3'd2, 20);
    check("t2_h151", 32'(heater), 0);
    adc_data = 12'd2384;
    cycles(15);
    check("t2_temp149a", 32'(cur_temp), 149);
    check("t2_h149_off", 32'(heater), 0);
    adc_data = 12'd2352;
    cycles(15);
    check("t2_temp147", 32'(cur_temp), 147);
    check("t2_h147_on", 32'(heater), 1);
    adc_data = 12'd2384;
    cycles(15);
    check("t2_temp149b", 32'(cur_temp), 149);
    check("t2_h149_on", 32'(heater), 1);
    check("t2_still_hold", 32'(state), 2);

    // 4. Abort: simultaneous start and stop while in HOLD
    @(negedge clk) begin start = 1'b1; stop = 1'b1; end
    cycles(1);
    check("t4_cool", 32'(state), 3);
    check("t4_heater_off", 32'(heater), 0);
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    adc_data = 12'd700;
    wait_state("t4_idle", 3'd0, 20);
    check("t4_done_low", 32'(done), 0);

    // 3. Preheat timeout with ADC stuck at 100 degC
    set_timer = 4'd2; adc_data = 12'd1600;
    @(negedge clk) start = 1'b1;
    cycles(1);
    check("t3_preheat", 32'(state), 1);
    @(negedge clk) start = 1'b0;
    cycles(49);
    check("t3_before_timeout", 32'(state), 1);
    check("t3_temp100", 32'(cur_temp), 100);
    cycles(1);
    check("t3_fault_state", 32'(state), 5);
    check("t3_fault", 32'(fault), 1);
    check("t3_heater_off", 32'(heater), 0);
    @(negedge clk) start = 1'b1;
    cycles(2);
    check("t3_start_ignored", 32'(state), 5);
    @(negedge clk) start = 1'b0;
    @(negedge clk) stop = 1'b1;
    cycles(1);
    check("t3_stop_idle", 32'(state), 0);
    check("t3_fault_clr", 32'(fault), 0);
    @(negedge clk) stop = 1'b0;

    // 5. Asynchronous reset mid-PREHEAT
    set_timer = 4'd1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cycles(3);
    check("t5_pre_heater", 32'(heater), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_heater", 32'(heater), 0);
    check("t5_adc_req", 32'(adc_req), 0);
    check("t5_state", 32'(state), 0);
    check("t5_cur_temp", 32'(cur_temp), 0);
    check("t5_remaining", 32'(remaining_s), 0);
    check("t5_done", 32'(done), 0);
    check("t5_fault", 32'(fault), 0);

    // 6. Boundaries: stray valid, zero timer, open sensor
    adc_auto = 1'b0;
    @(negedge clk) begin rst_n = 1'b1; adc_data = 12'd2416; man_valid = 1'b1; end
    cycles(1);
    check("t6_stray_valid", 32'(cur_temp), 0);
    check("t6_no_req", 32'(adc_req), 0);
    set_temp = 8'd150; set_timer = 4'd0;
    @(negedge clk) begin man_valid = 1'b0; start = 1'b1; end
    cycles(2);
    check("t6_timer0_idle", 32'(state), 0);
    check("t6_timer0_heater", 32'(heater), 0);
    @(negedge clk) start = 1'b0;
    set_timer = 4'd1; adc_data = 12'd4095; adc_auto = 1'b1;
    @(negedge clk) start = 1'b1;
    cycles(1);
    check("t6_preheat", 32'(state), 1);
    @(negedge clk) start = 1'b0;
    wait_state("t6_sensor_fault", 3'd5, 20);
    check("t6_fault", 32'(fault), 1);
    check("t6_heater_off", 32'(heater), 0);
    check("t6_temp255", 32'(cur_temp), 255);
    @(negedge clk) stop = 1'b1;
    cycles(1);
    check("t6_stop_idle", 32'(state), 0);
    @(negedge clk) stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
